// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

  localparam int          CNT_W_DEF   = 31;
  localparam int unsigned TIMEOUT_DEF = 200_000_000;

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus delay register; flags a rising edge of the synchronised level.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2, sd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      sd <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~sd;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and high time of a slow asynchronous square wave in clk cycles.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic             level, rise;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sig_in),
    .level (level),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      pcnt       <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ACQUIRE: begin
          if (rise) begin
            pcnt  <= '0;
            hcnt  <= ONE;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          // A rise on the final count still publishes: it is checked first.
          if (rise) begin
            period     <= pcnt + ONE;
            high_time  <= hcnt;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            pcnt       <= '0;
            hcnt       <= ONE;
          end else if (pcnt == PCNT_LAST) begin
            timeout <= 1'b1;
            pcnt    <= '0;
            hcnt    <= '0;
            state   <= ACQUIRE;
          end else begin
            pcnt <= pcnt + ONE;
            if (level) hcnt <= hcnt + ONE;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

  assign locked = (state == MEASURE);

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, externally generated square wave, such as a divided-down 1 Hz tick, in cycles of the 100 MHz system clock. It is the receiving end of the clock-divider path. It synchronises the incoming signal, detects rising edges, counts system clocks between successive rising edges, and publishes each completed measurement with a one-cycle valid strobe. It sits on the board-level test path: the divided clock loops back into it, and the board checks the measurements against the divider ratio.

## Interface
Parameters:
- CNT_W, 31: width of the period and high-time counters and outputs.
- TIMEOUT, 200000000: number of cycles without a rising edge before the measurement is declared stale. Must satisfy TIMEOUT ≤ 2^CNT_W − 1.

Ports:
- clk, input, 1: system clock. All state is on the rising edge.
- rst, input, 1: reset. Asynchronous and active-low: rst = 0 resets the block.
- sig_in, input, 1: measured signal. Asynchronous to clk.
- period, output, CNT_W: last measured period in clk cycles (rise to rise).
- high_time, output, CNT_W: last measured high time in clk cycles.
- meas_valid, output, 1: one-cycle pulse when period and high_time update.
- timeout, output, 1: sticky flag set when TIMEOUT cycles pass with no rising edge.
- locked, output, 1: high while in state MEASURE.

## Operation
Input conditioning:
- Two-flop synchroniser: sig_in → s1 → s2.
- One delay register: s2 → sd.
- rise = s2 & ~sd. This is combinational and internal.

State machine (two states):
- ACQUIRE (reset state):
  - Wait for a rise.
  - On rise: clear pcnt to 0, set hcnt to 1, go to MEASURE.
  - No measurement is published.
- MEASURE, on rise:
  - period ← pcnt + 1 and high_time ← hcnt.
  - meas_valid pulses for 1 cycle and timeout clears.
  - pcnt ← 0, hcnt ← 1, stay in MEASURE.
- MEASURE, otherwise:
  - pcnt ← pcnt + 1.
  - hcnt ← hcnt + 1 if s2 = 1, else hcnt holds.
  - If pcnt = TIMEOUT − 1 with no rise: set timeout, clear pcnt and hcnt, go to ACQUIRE.

General rules:
- period and high_time hold their last values between updates and across a timeout.
- A signal stuck high or stuck low produces no measurement and ends in timeout.
- The minimum measurable period is 2 cycles: high 1, low 1 as seen at s2.
- Counter arithmetic is unsigned CNT_W bits. Because TIMEOUT ≤ 2^CNT_W − 1, the counters never wrap.
- On rise coinciding with the timeout condition, the rise wins:
  - The measurement is published and timeout stays clear.
  - The FSM stays in MEASURE.

## Timing
- Reset values:
  - period = 0, high_time = 0, meas_valid = 0, timeout = 0, locked = 0.
  - s1, s2 and sd = 0; state = ACQUIRE.
- Edge latency: sig_in rises before clk edge k, so s2 = 1 after edge k+1 and rise is asserted during the cycle after edge k+1. Results register at edge k+2.
  - meas_valid, period and high_time change together at that edge.
  - Net input-to-output latency is 3 clk edges.
- Reset asserted mid-measurement:
  - All outputs return to reset values immediately, without waiting for clk.
  - After release, the first rise only re-arms; the second rise produces the first meas_valid.
- locked rises on the edge that enters MEASURE and falls on the edge that sets timeout.

## Structure
Shared package clk_meas_pkg holds:
- The state enum {ACQUIRE, MEASURE}.
- Default constants for CNT_W and TIMEOUT.

Sub-module sync_edge_det:
- Contains the two-flop synchroniser, the delay register and the rise output.
- Is reused by other asynchronous inputs.
- Resets to all-zero on rst = 0.

The top level holds the FSM, both counters and the output registers.

## Test plan
Run the bench with CNT_W = 8 and TIMEOUT = 100.
- Square wave, 5 cycles high / 5 low, for 4 periods → first meas_valid on the 2nd rise, then every 10 cycles; period = 10, high_time = 5, timeout = 0, locked = 1.
- Duty change to 3 high / 7 low after 2 periods → next measurement period = 10, high_time = 3. The measurement straddling the change shows the mixed value exactly once.
- sig_in held low after lock → timeout = 1 and locked = 0 exactly 100 cycles after the last rise; period and high_time keep their old values. The next two rises re-lock, and the second clears timeout with a fresh measurement.
- Minimum period, 1 high / 1 low → period = 2 and high_time = 1 on every rise after the first.
- rst pulsed low for 1 cycle mid-period → outputs go to 0 asynchronously and state = ACQUIRE; the first meas_valid comes only after two further rises.
- Rise landing exactly on pcnt = 99 → meas_valid with period = 100, no timeout, locked stays 1.
